sobel_frame_ctrl: RTL and testbench

SOBEL_FRAME_CTRL -- requirements
Module: sobel_frame_ctrl

---
 rtl/sobel_pkg.sv | 16 +
 rtl/frame_counter.sv | 51 +++++
 rtl/sobel_frame_ctrl.sv | 115 +++++++++++
 tb/tb_sobel_frame_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel frame controller.
package sobel_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StFlush,
      StDone
   } state_e;

   // Width able to hold the value max_cnt itself, not just max_cnt-1.
   function automatic int unsigned cnt_w(input int unsigned max_cnt);
      return $clog2(max_cnt) + 1;
   endfunction

endpackage

// File: rtl/frame_counter.sv
// Column/row raster counter; last_o flags the final pixel of the frame.
module frame_counter
   import sobel_pkg::*;
#(
   parameter int unsigned LINE_W_P  = 640,
   parameter int unsigned FRAME_H_P = 480
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic inc_i,
   output logic last_o
);

   localparam int unsigned ColW = cnt_w(LINE_W_P);
   localparam int unsigned RowW = cnt_w(FRAME_H_P);

   logic [ColW-1:0] col_q, col_d;
   logic [RowW-1:0] row_q, row_d;
   logic            col_last, row_last;

   always_comb begin
      col_last = (col_q == ColW'(LINE_W_P - 1));
      row_last = (row_q == RowW'(FRAME_H_P - 1));
      last_o   = col_last && row_last;
      col_d    = col_q;
      row_d    = row_q;
      if (clr_i) begin
         col_d = '0;
         row_d = '0;
      end else if (inc_i) begin
         if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + RowW'(1);
         end else begin
            col_d = col_q + ColW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer around a 3x3 conv2d: feeds a frame, flushes the line buffer
// with zeros, drops the warm-up results and forwards exactly one frame of results.
module sobel_frame_ctrl
   import sobel_pkg::*;
#(
   parameter int unsigned WIDTH_P   = 8,
   parameter int unsigned RES_W_P   = 32,
   parameter int unsigned LINE_W_P  = 640,
   parameter int unsigned FRAME_H_P = 480
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   output logic               busy_o,
   output logic               done_o,
   input  logic [WIDTH_P-1:0] pix_data_i,
   input  logic               pix_valid_i,
   output logic               pix_ready_o,
   output logic [WIDTH_P-1:0] conv_data_o,
   output logic               conv_valid_o,
   input  logic               conv_ready_i,
   input  logic [RES_W_P-1:0] res_data_i,
   input  logic               res_valid_i,
   output logic               res_ready_o,
   output logic [RES_W_P-1:0] res_data_o,
   output logic               res_valid_o,
   input  logic               res_ready_i
);

   localparam int unsigned FlushN = LINE_W_P + 1;
   localparam int unsigned Total  = LINE_W_P * FRAME_H_P;
   localparam int unsigned FlushW = cnt_w(FlushN);
   localparam int unsigned FwdW   = cnt_w(Total);

   state_e            state_q;
   logic [FlushW-1:0] flush_q;
   logic [FlushW-1:0] drop_q;
   logic [FwdW-1:0]   fwd_q;

   logic start_go, active, pass;
   logic flush_done, drop_done, fwd_done;
   logic pix_hs, flush_hs, drop_hs, fwd_hs, pix_last;

   frame_counter #(
      .LINE_W_P  (LINE_W_P),
      .FRAME_H_P (FRAME_H_P)
   ) u_in_cnt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (start_go),
      .inc_i  (pix_hs),
      .last_o (pix_last)
   );

   always_comb begin
      start_go   = (state_q == StIdle) && start_i;
      active     = (state_q == StRun) || (state_q == StFlush);
      flush_done = (flush_q == FlushW'(FlushN));
      drop_done  = (drop_q == FlushW'(FlushN));
      fwd_done   = (fwd_q == FwdW'(Total));
      pass       = active && drop_done && !fwd_done;

      busy_o       = (state_q != StIdle);
      done_o       = (state_q == StDone);
      pix_ready_o  = 1'b0;
      conv_valid_o = 1'b0;
      conv_data_o  = '0;
      unique case (state_q)
         StRun: begin
            conv_valid_o = pix_valid_i;
            conv_data_o  = pix_data_i;
            pix_ready_o  = conv_ready_i;
         end
         StFlush: conv_valid_o = !flush_done;
         default: ;
      endcase

      // Warm-up results are swallowed; once a frame's worth is out, hold off the rest.
      res_ready_o = active && (!drop_done || (!fwd_done && res_ready_i));
      res_valid_o = pass && res_valid_i;
      res_data_o  = pass ? res_data_i : '0;

      pix_hs   = (state_q == StRun) && pix_valid_i && conv_ready_i;
      flush_hs = (state_q == StFlush) && !flush_done && conv_ready_i;
      drop_hs  = active && !drop_done && res_valid_i;
      fwd_hs   = pass && res_valid_i && res_ready_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         flush_q <= '0;
         drop_q  <= '0;
         fwd_q   <= '0;
      end else begin
         if (start_go) begin
            flush_q <= '0;
            drop_q  <= '0;
            fwd_q   <= '0;
         end else begin
            if (flush_hs) flush_q <= flush_q + FlushW'(1);
            if (drop_hs)  drop_q  <= drop_q + FlushW'(1);
            if (fwd_hs)   fwd_q   <= fwd_q + FwdW'(1);
         end
         unique case (state_q)
            StIdle:  if (start_i) state_q <= StRun;
            StRun:   if (pix_hs && pix_last) state_q <= StFlush;
            StFlush: if (flush_done && fwd_done) state_q <= StDone;
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Randomised frame-level bench: a queue-based conv2d stand-in plus scoreboards.
module tb_sobel_frame_ctrl;

   localparam int unsigned W   = 8;
   localparam int unsigned RW  = 32;
   localparam int unsigned LW  = 4;
   localparam int unsigned FH  = 3;
   localparam int NPIX   = LW * FH;
   localparam int NFLUSH = LW + 1;
   localparam int NRES   = NPIX + NFLUSH;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          start_i;
   logic          busy_o, done_o;
   logic [W-1:0]  pix_data_i;
   logic          pix_valid_i, pix_ready_o;
   logic [W-1:0]  conv_data_o;
   logic          conv_valid_o, conv_ready_i;
   logic [RW-1:0] res_data_i;
   logic          res_valid_i, res_ready_o;
   logic [RW-1:0] res_data_o;
   logic          res_valid_o, res_ready_i;

   sobel_frame_ctrl #(
      .WIDTH_P   (W),
      .RES_W_P   (RW),
      .LINE_W_P  (LW),
      .FRAME_H_P (FH)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .pix_data_i   (pix_data_i),
      .pix_valid_i  (pix_valid_i),
      .pix_ready_o  (pix_ready_o),
      .conv_data_o  (conv_data_o),
      .conv_valid_o (conv_valid_o),
      .conv_ready_i (conv_ready_i),
      .res_data_i   (res_data_i),
      .res_valid_i  (res_valid_i),
      .res_ready_o  (res_ready_o),
      .res_data_o   (res_data_o),
      .res_valid_o  (res_valid_o),
      .res_ready_i  (res_ready_i)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   logic [W-1:0]  pix [NPIX];
   logic [W-1:0]  conv_log [$];
   logic [RW-1:0] pending [$];
   logic [RW-1:0] produced [$];
   logic [RW-1:0] fwd_log [$];
   int src_idx, res_taken, done_cnt;

   task automatic drive_idle();
      start_i      = 1'b0;
      pix_valid_i  = 1'b0;
      pix_data_i   = '0;
      conv_ready_i = 1'b0;
      res_valid_i  = 1'b0;
      res_data_i   = '0;
      res_ready_i  = 1'b0;
   endtask

   task automatic run_frame(input string tag, input int pv, input int cr, input int rr,
                            input bit start_mid, input int abort_at, input bit hold_flush,
                            input bit extra_res);
      int       hold_cnt = 0;
      int       done_early = 0;
      bit       finishing = 0, finished = 0, mid_done = 0;
      bit       extra_armed = 0, extra_chk = 0, hold = 0;
      logic [15:0]   r_id = '0;
      logic [RW-1:0] r;
      for (int i = 0; i < NPIX; i++) pix[i] = W'($urandom);
      conv_log.delete();
      pending.delete();
      produced.delete();
      fwd_log.delete();
      src_idx   = 0;
      res_taken = 0;
      done_cnt  = 0;

      @(posedge clk); #1;
      check({tag, "/idle_busy"}, busy_o, 0);
      start_i = 1'b1;
      for (int cyc = 0; cyc < 800 && !finished; cyc++) begin
         @(posedge clk); #1;
         pix_valid_i  = ($urandom_range(99) < pv);
         pix_data_i   = (src_idx < NPIX) ? pix[src_idx] : 8'hEE;
         conv_ready_i = ($urandom_range(99) < cr);
         res_valid_i  = (pending.size() > 0) && ($urandom_range(99) < pv);
         res_data_i   = (pending.size() > 0) ? pending[0] : '0;
         hold         = hold_flush && (conv_log.size() < NRES || hold_cnt < 8);
         res_ready_i  = hold ? 1'b0 : ($urandom_range(99) < rr);
         start_i      = start_mid && (src_idx == 5) && !mid_done;
         if (start_i) mid_done = 1;
         if (extra_armed) begin
            res_valid_i = 1'b1;
            res_data_i  = 32'hDEAD_BEEF;
            extra_armed = 0;
            extra_chk   = 1;
         end

         @(negedge clk);
         if (finishing) begin
            check({tag, "/busy_after_done"}, busy_o, 0);
            finished = 1;
         end else begin
            if (extra_chk) begin
               check({tag, "/extra_res_ready"}, res_ready_o, 0);
               check({tag, "/extra_res_valid"}, res_valid_o, 0);
               extra_chk = 0;
            end
            if (pix_valid_i && pix_ready_o) src_idx++;
            if (res_valid_i && res_ready_o) begin
               res_taken++;
               if (pending.size() > 0) void'(pending.pop_front());
            end
            if (conv_valid_o && conv_ready_i) begin
               conv_log.push_back(conv_data_o);
               r = {r_id, 8'h5A, conv_data_o};
               r_id++;
               pending.push_back(r);
               produced.push_back(r);
            end
            if (res_valid_o && res_ready_i) begin
               fwd_log.push_back(res_data_o);
               if (extra_res && fwd_log.size() == NPIX) extra_armed = 1;
            end
            if (hold_flush && conv_log.size() >= NRES) begin
               hold_cnt++;
               if (hold_cnt == 8) check({tag, "/hold_busy"}, busy_o, 1);
            end
            if (done_o) begin
               done_cnt++;
               if (hold) done_early++;
               finishing = 1;
               if (start_mid) start_i = 1'b1;
            end
            if (abort_at >= 0 && src_idx == abort_at) begin
               #2 rst_i = 1'b1;
               #1 check({tag, "/abort_outputs"},
                        {busy_o, done_o, pix_ready_o, conv_valid_o, res_ready_o, res_valid_o}, 0);
               drive_idle();
               @(posedge clk); #1 rst_i = 1'b0;
               return;
            end
         end
      end

      if (!finished) check({tag, "/timeout"}, 0, 1);
      check({tag, "/pixels_taken"}, src_idx, NPIX);
      check({tag, "/conv_count"}, conv_log.size(), NRES);
      for (int i = 0; i < NRES; i++) begin
         if (i < conv_log.size())
            check({tag, "/conv_data"}, conv_log[i], (i < NPIX) ? pix[i] : '0);
      end
      check({tag, "/results_taken"}, res_taken, NRES);
      check({tag, "/fwd_count"}, fwd_log.size(), NPIX);
      for (int k = 0; k < NPIX; k++) begin
         if (k < fwd_log.size() && (k + NFLUSH) < produced.size())
            check({tag, "/fwd_data"}, fwd_log[k], produced[k + NFLUSH]);
      end
      check({tag, "/done_pulses"}, done_cnt, 1);
      if (hold_flush) check({tag, "/done_during_hold"}, done_early, 0);
      drive_idle();
   endtask

   initial begin
      rst_i = 1'b1;
      drive_idle();
      #12;
      check("reset_outputs",
            {busy_o, done_o, pix_ready_o, conv_valid_o, res_ready_o, res_valid_o}, 0);
      @(posedge clk); #1 rst_i = 1'b0;
      check("post_reset_busy", busy_o, 0);

      run_frame("always_ready", 100, 100, 100, 0, -1, 0, 0);
      for (int n = 0; n < 3; n++) run_frame("random_stall", 60, 60, 60, 0, -1, 0, 0);
      run_frame("start_ignored", 70, 70, 70, 1, -1, 0, 0);
      run_frame("abort", 100, 100, 100, 0, 7, 0, 0);
      run_frame("after_abort", 75, 75, 75, 0, -1, 0, 0);
      run_frame("hold_flush", 80, 80, 80, 0, -1, 1, 0);
      run_frame("extra_result", 100, 100, 100, 0, -1, 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
